pll_lock_sequencer: RTL and testbench

Controls the PLL's reset and power-down inputs and qualifies its LOCKED output.
- Produces a clean downstream reset (USER_RST) that deasserts only after LOCKED has been stably high.
- Retries the PLL reset on lock timeout and re-sequences on loss of lock.
- Runs on the free-running reference clock that also drives the PLL input clock.
- Sits between system reset logic and the PLL primitive wrapper.

---
 rtl/pll_lock_sequencer_pkg.sv | 36 +++
 rtl/pll_lock_sequencer_sync_2ff.sv | 23 ++
 rtl/pll_lock_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_sequencer_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding, synchronizer
// depth and the registered output bundle decoded from the FSM state.
package pll_lock_sequencer_pkg;

    localparam int unsigned SYNC_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAULT     = 3'd6
    } seq_state_e;

    typedef struct packed {
        logic pwrdwn;
        logic pll_rst;
        logic user_rst;
        logic ready;
        logic fail;
    } seq_out_t;

    // Output levels implied by being in a given state
    function automatic seq_out_t decode_out(input seq_state_e s);
        seq_out_t o;
        o.pwrdwn   = (s == ST_OFF);
        o.pll_rst  = (s == ST_OFF) || (s == ST_RESET) || (s == ST_FAULT);
        o.user_rst = (s != ST_RUN);
        o.ready    = (s == ST_RUN);
        o.fail     = (s == ST_FAULT);
        return o;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Generic single-bit synchronizer (SYNC_DEPTH flops) with async active-low clear.
module pll_lock_sequencer_sync_2ff
    import pll_lock_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/power-down sequencer with lock qualification, timeout retries and
// user reset release. Optional PLL_LOSS_COUNT_EN adds a RUN lock-loss counter.
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned LOCK_TIMEOUT   = 1000,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned RELEASE_CYCLES = 8,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned RTY_W          = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             locked,
    output logic             pll_rst,
    output logic             pll_pwrdwn,
    output logic             user_rst,
    output logic             ready,
    output logic             fail,
    output logic [RTY_W-1:0] retry_cnt
`ifdef PLL_LOSS_COUNT_EN
    ,
    output logic [7:0]       loss_cnt
`endif
);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] tmo_inc;
    logic [RTY_W-1:0] rty_q, rty_d;
    seq_out_t         out_q;
    logic             lock_s;
    logic             tmo_done;
    logic             do_retry;

    pll_lock_sequencer_sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (locked),
        .q     (lock_s)
    );

    // Timeout counter holds at all-ones rather than wrapping
    assign tmo_inc  = (tmo_q == '1) ? tmo_q : tmo_q + CNT_W'(1);
    assign tmo_done = (tmo_q == TMO_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        rty_d    = rty_q;
        do_retry = 1'b0;

        if (!enable) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                    rty_d   = '0;
                end
                ST_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        tmo_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    tmo_d = tmo_inc;
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (tmo_done) begin
                        do_retry = 1'b1;
                    end
                end
                ST_STABLE: begin
                    tmo_d = tmo_inc;
                    if (lock_s && (cnt_q == STB_LAST)) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                    end else if (tmo_done) begin
                        do_retry = 1'b1;
                    end else if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!lock_s) begin
                        do_retry = 1'b1;
                    end else if (cnt_q == REL_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // Lock loss after release starts a fresh attempt
                    if (!lock_s) begin
                        state_d = ST_RESET;
                        cnt_d   = '0;
                        rty_d   = '0;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase

            if (do_retry) begin
                if (rty_q == RTY_MAX) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                    rty_d   = rty_q + RTY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            tmo_q   <= '0;
            rty_q   <= '0;
            out_q   <= decode_out(ST_OFF);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            rty_q   <= rty_d;
            out_q   <= decode_out(state_d);
        end
    end

    assign pll_pwrdwn = out_q.pwrdwn;
    assign pll_rst    = out_q.pll_rst;
    assign user_rst   = out_q.user_rst;
    assign ready      = out_q.ready;
    assign fail       = out_q.fail;
    assign retry_cnt  = rty_q;

`ifdef PLL_LOSS_COUNT_EN
    logic [7:0] loss_q;
    logic       lock_loss_c;

    assign lock_loss_c = (state_q == ST_RUN) && (state_d == ST_RESET);

    // Saturating count of lock losses seen while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (state_d == ST_OFF) begin
            loss_q <= '0;
        end else if (lock_loss_c && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: timestamp-based reference model,
// directed scenarios with literal timing expectations, then random lock/enable traffic.
module tb_pll_lock_sequencer;

    localparam int RSTC = 4;
    localparam int LT   = 64;
    localparam int SC   = 16;
    localparam int RC   = 8;
    localparam int MAXR = 2;

    localparam int P_OFF  = 10;
    localparam int P_RST  = 11;
    localparam int P_WAIT = 12;
    localparam int P_STB  = 13;
    localparam int P_REL  = 14;
    localparam int P_RUN  = 15;
    localparam int P_FLT  = 16;

    localparam int S_PLLRST = 0;
    localparam int S_PWRDWN = 1;
    localparam int S_USRRST = 2;
    localparam int S_READY  = 3;
    localparam int S_FAIL   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       locked;
    logic       pll_rst;
    logic       pll_pwrdwn;
    logic       user_rst;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
`ifdef PLL_LOSS_COUNT_EN
    logic [7:0] loss_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state: phase plus timestamps in clock edges
    int m_ph   = P_OFF;
    int m_n    = 0;
    int m_t_ph = 0;
    int m_t_w  = 0;
    int m_rty  = 0;
    int m_loss = 0;
    bit m_l1   = 1'b0;
    bit m_l2   = 1'b0;
    bit m_ls;
    int m_el;

    pll_lock_sequencer #(
        .RST_CYCLES     (RSTC),
        .LOCK_TIMEOUT   (LT),
        .STABLE_CYCLES  (SC),
        .RELEASE_CYCLES (RC),
        .MAX_RETRIES    (MAXR),
        .CNT_W          (16),
        .RTY_W          (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .locked     (locked),
        .pll_rst    (pll_rst),
        .pll_pwrdwn (pll_pwrdwn),
        .user_rst   (user_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
`ifdef PLL_LOSS_COUNT_EN
        ,
        .loss_cnt   (loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic get_sig(input int which);
        case (which)
            S_PLLRST: return pll_rst;
            S_PWRDWN: return pll_pwrdwn;
            S_USRRST: return user_rst;
            S_READY:  return ready;
            default:  return fail;
        endcase
    endfunction

    task automatic wait_sig(input string nm, input int which, input logic val,
                            input int maxc, output int n);
        n = 0;
        while (get_sig(which) !== val && n < maxc) begin
            tick();
            n++;
        end
        if (get_sig(which) !== val) begin
            checks++;
            errors++;
            $display("FAIL %s: wait expired after %0d cycles", nm, n);
        end
    endtask

    task automatic m_retry();
        if (m_rty < MAXR) begin
            m_ph   = P_RST;
            m_t_ph = m_n;
            m_rty++;
        end else begin
            m_ph = P_FLT;
        end
    endtask

    // Reference model: advances on each clock edge, resets asynchronously
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ph = P_OFF; m_rty = 0; m_loss = 0; m_l1 = 1'b0; m_l2 = 1'b0;
            m_n = 0; m_t_ph = 0; m_t_w = 0;
        end else begin
            m_ls = m_l2;
            m_l2 = m_l1;
            m_l1 = locked;
            m_n++;
            m_el = m_n - m_t_w;
            if (!enable) begin
                m_ph   = P_OFF;
                m_loss = 0;
            end else begin
                case (m_ph)
                    P_OFF: begin m_ph = P_RST; m_t_ph = m_n; m_rty = 0; end
                    P_RST: if (m_n - m_t_ph == RSTC) begin m_ph = P_WAIT; m_t_w = m_n; end
                    P_WAIT: begin
                        if (m_ls) begin m_ph = P_STB; m_t_ph = m_n; end
                        else if (m_el == LT) m_retry();
                    end
                    P_STB: begin
                        if (m_ls && (m_n - m_t_ph == SC)) begin m_ph = P_REL; m_t_ph = m_n; end
                        else if (m_el == LT) m_retry();
                        else if (!m_ls) m_ph = P_WAIT;
                    end
                    P_REL: begin
                        if (!m_ls) m_retry();
                        else if (m_n - m_t_ph == RC) m_ph = P_RUN;
                    end
                    P_RUN: begin
                        if (!m_ls) begin
                            m_ph = P_RST; m_t_ph = m_n; m_rty = 0;
                            if (m_loss < 255) m_loss++;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk);
        chk("pll_pwrdwn", 32'(pll_pwrdwn), 32'(m_ph == P_OFF));
        chk("pll_rst", 32'(pll_rst), 32'(m_ph == P_OFF || m_ph == P_RST || m_ph == P_FLT));
        chk("user_rst", 32'(user_rst), 32'(m_ph != P_RUN));
        chk("ready", 32'(ready), 32'(m_ph == P_RUN));
        chk("fail", 32'(fail), 32'(m_ph == P_FLT));
        chk("retry_cnt", 32'(retry_cnt), 32'(m_rty));
`ifdef PLL_LOSS_COUNT_EN
        chk("loss_cnt", 32'(loss_cnt), 32'(m_loss));
`endif
    end

    int n;
    int hi;
    int bad;
    int t;
    int nseg;
    bit prev;
    bit cur;
    int seg_start[3];
    int seg_end[3];
    int seg_rty[3];
    int r;

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        locked = 1'b0;
        repeat (3) tick();
        chk("rst_pwrdwn", 32'(pll_pwrdwn), 1);
        chk("rst_pll_rst", 32'(pll_rst), 1);
        chk("rst_user_rst", 32'(user_rst), 1);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_fail", 32'(fail), 0);
        chk("rst_retry", 32'(retry_cnt), 0);

        // Nominal lock
        rst_n = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        hi = 0;
        while (pll_rst === 1'b1 && pll_pwrdwn === 1'b0 && hi < 20) begin hi++; tick(); end
        chk("t1_rst_pulse_len", 32'(hi), 4);
        chk("t1_retry", 32'(retry_cnt), 0);
        repeat (9) tick();
        locked = 1'b1;
        wait_sig("t1_ready_wait", S_READY, 1'b1, 100, n);
        chk("t1_lock_to_ready", 32'(n - 1), 26);
        chk("t1_user_rst_low", 32'(user_rst), 0);

        // Lock loss while running
        repeat (3) tick();
        locked = 1'b0;
        wait_sig("t4_user_rst_wait", S_USRRST, 1'b1, 10, n);
        chk("t4_loss_to_user_rst", 32'(n - 1), 2);
        chk("t4_ready_low", 32'(ready), 0);
`ifdef PLL_LOSS_COUNT_EN
        chk("t4_loss_cnt", 32'(loss_cnt), 1);
`endif
        hi = 0;
        while (pll_rst === 1'b1 && pll_pwrdwn === 1'b0 && hi < 20) begin hi++; tick(); end
        chk("t4_rst_pulse_len", 32'(hi), 4);
        chk("t4_retry", 32'(retry_cnt), 0);

        // Enable dropped while waiting for lock on the first retry
        n = 0;
        while (retry_cnt !== 2'd1 && n < 200) begin tick(); n++; end
        chk("t6_reach_retry1", 32'(retry_cnt), 1);
        wait_sig("t6_wait_lock", S_PLLRST, 1'b0, 20, n);
        repeat (5) tick();
        enable = 1'b0;
        tick();
        chk("t6_pwrdwn", 32'(pll_pwrdwn), 1);
        chk("t6_pll_rst", 32'(pll_rst), 1);
        enable = 1'b1;
        tick();
        chk("t6_restart_retry", 32'(retry_cnt), 0);
        chk("t6_restart_pwrdwn", 32'(pll_pwrdwn), 0);
        chk("t6_restart_pll_rst", 32'(pll_rst), 1);

        // Lock timeout with LOCKED stuck low
        nseg = 0;
        prev = 1'b0;
        for (t = 0; t < 400 && fail !== 1'b1; t++) begin
            cur = (pll_rst === 1'b1) && (pll_pwrdwn === 1'b0) && (fail === 1'b0);
            if (cur && !prev && nseg < 3) begin seg_start[nseg] = t; seg_rty[nseg] = int'(retry_cnt); end
            if (!cur && prev && nseg < 3) begin seg_end[nseg] = t; nseg++; end
            prev = cur;
            tick();
        end
        chk("t2_pulse_count", 32'(nseg), 3);
        if (nseg == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t2_pulse_len", 32'(seg_end[i] - seg_start[i]), 4);
                chk("t2_pulse_retry", 32'(seg_rty[i]), 32'(i));
            end
            chk("t2_gap1", 32'(seg_start[1] - seg_end[0]), 64);
            chk("t2_gap2", 32'(seg_start[2] - seg_end[1]), 64);
            chk("t2_fault_gap", 32'(t - seg_end[2]), 64);
        end
        chk("t2_fail", 32'(fail), 1);
        chk("t2_fault_pll_rst", 32'(pll_rst), 1);
        chk("t2_fault_user_rst", 32'(user_rst), 1);
        repeat (5) tick();
        chk("t2_fail_sticky", 32'(fail), 1);
        enable = 1'b0;
        tick();
        chk("t2_off_fail", 32'(fail), 0);
        chk("t2_off_pwrdwn", 32'(pll_pwrdwn), 1);

        // Lock glitch during stability qualification
        enable = 1'b1;
        wait_sig("t3_wait_lock", S_PLLRST, 1'b0, 20, n);
        bad = 0;
        locked = 1'b1;
        repeat (5) begin tick(); if (user_rst !== 1'b1) bad++; end
        locked = 1'b0;
        repeat (3) begin tick(); if (user_rst !== 1'b1) bad++; end
        locked = 1'b1;
        wait_sig("t3_ready_wait", S_READY, 1'b1, 100, n);
        chk("t3_user_rst_held", 32'(bad), 0);
        chk("t3_final_rise_to_ready", 32'(n - 1), 26);

        // Asynchronous reset in the middle of RELEASE
        locked = 1'b0;
        wait_sig("t5_user_rst_wait", S_USRRST, 1'b1, 10, n);
        wait_sig("t5_wait_lock", S_PLLRST, 1'b0, 20, n);
        locked = 1'b1;
        repeat (22) tick();
        chk("t5_in_release_ready", 32'(ready), 0);
        chk("t5_in_release_user_rst", 32'(user_rst), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_pwrdwn", 32'(pll_pwrdwn), 1);
        chk("t5_async_pll_rst", 32'(pll_rst), 1);
        chk("t5_async_user_rst", 32'(user_rst), 1);
        chk("t5_async_ready", 32'(ready), 0);
        chk("t5_async_fail", 32'(fail), 0);
        chk("t5_async_retry", 32'(retry_cnt), 0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_sig("t5_rerun_ready", S_READY, 1'b1, 80, n);

        // Randomised lock, enable and reset traffic against the model
        for (int s = 0; s < 150; s++) begin
            r = int'($urandom_range(0, 39));
            if (r == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else if (r < 4) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
                enable = 1'b1;
            end
            locked = ~locked;
            if (locked) repeat ($urandom_range(1, 70)) tick();
            else        repeat ($urandom_range(1, 90)) tick();
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
